emu_ff_scan_ctrl: RTL and testbench
===================================

EMU_FF_SCAN_CTRL -- requirements
Module: emu_ff_scan_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_BEATS, default 3: number of 64-bit beats in the FF scan chain, legal range 1..65535.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: scan beat width, matching the scan chain SDI/SDO width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- start_dump  in  1  one-cycle request to dump the chain.
- start_restore  in  1  one-cycle request to restore the chain.
- abort  in  1  cancels the operation in progress.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when an operation completes.
- halt  out  1  DUT halt request.
- ff_scan  out  1  chain shift enable.
- ff_sdi  out  DATA_WIDTH  chain scan input.
- ff_sdo  in  DATA_WIDTH  chain scan output.
- dout_valid / dout_ready / dout_data  out/in/out  1/1/DATA_WIDTH  dump beat stream.
- din_valid / din_ready / din_data  in/out/in  1/1/DATA_WIDTH  restore beat stream.
- checksum  out  DATA_WIDTH  XOR of all beats transferred in the last operation.

Function
REQ-005 SHALL implement FSM states IDLE, DUMP, RESTORE, FIN; state and beat counter registered.
REQ-006 In IDLE with start_dump=1, SHALL go to DUMP next cycle; if only start_restore=1, SHALL go to RESTORE; if both are 1, DUMP wins.
REQ-007 SHALL ignore start_dump and start_restore outside IDLE.
REQ-008 halt SHALL be 1 in DUMP, RESTORE and FIN, and 0 in IDLE; busy SHALL equal halt.
REQ-009 In DUMP: dout_valid=1; dout_data=ff_sdo; ff_sdi=ff_sdo (loopback, chain content preserved); ff_scan=dout_ready (combinational).
REQ-010 In RESTORE: din_ready=1; ff_sdi=din_data; ff_scan=din_valid (combinational).
REQ-011 A beat SHALL be transferred exactly in cycles with ff_scan=1; the beat counter increments per transfer and the chain never shifts without a transfer.
REQ-012 A transfer with counter=CHAIN_BEATS-1 SHALL move the FSM to FIN and clear the counter.
REQ-013 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-014 Minimum op latency: start to done = CHAIN_BEATS+1 cycles with no backpressure or starvation.
REQ-015 Outside DUMP: dout_valid=0. Outside RESTORE: din_ready=0. ff_scan=0 in IDLE and FIN. ff_sdi=0 in IDLE and FIN.
REQ-016 abort=1 in DUMP or RESTORE SHALL force ff_scan=0 that cycle and go to IDLE next cycle without done; partially shifted chain content is not repaired.
REQ-017 abort SHALL be ignored in IDLE and FIN.
REQ-018 Back-to-back: a start asserted in the cycle after FIN (IDLE) SHALL be accepted.

Reset
REQ-019 rst_n=0 SHALL immediately force state=IDLE, counter=0, checksum=0, done=0, halt=0, busy=0, ff_scan=0, dout_valid=0, din_ready=0, including mid-operation.
REQ-020 Release of rst_n SHALL be used only synchronously to clk.

Configuration
REQ-021 Macro EMU_FF_SCAN_CHECKSUM_EN defined: checksum SHALL clear on op start and XOR-accumulate each transferred beat (dout_data or din_data), holding its value from FIN until the next start.
REQ-022 Macro EMU_FF_SCAN_CHECKSUM_EN undefined: checksum SHALL be constant 0 and no accumulator register SHALL exist.

Structure
REQ-023 A shared package emu_ff_scan_pkg SHALL hold the FSM state enum and default DATA_WIDTH constant.
REQ-024 Single module with no sub-modules; the counter width is $clog2(CHAIN_BEATS+1).

Verification
REQ-025 CHAIN_BEATS=3, chain preloaded with A,B,C, dout_ready=1: start_dump -> dout beats A,B,C on consecutive cycles, done 4 cycles after start, chain still holds A,B,C, checksum=A^B^C when macro defined.
REQ-026 Dump with dout_ready toggling 1,0,0,1,1: ff_scan mirrors dout_ready, exactly 3 beats transferred, no duplicate or lost beat.
REQ-027 Restore din 64'h1111..., 64'h2222..., 64'h3333... with din_valid gaps: the following dump returns the same three values in order.
REQ-028 start_dump and start_restore asserted together: DUMP entered, din_ready stays 0.
REQ-029 abort after 1 beat: no done pulse, halt=0 next cycle, next start_dump accepted; rst_n=0 mid-RESTORE: all outputs reset in the same cycle.
REQ-030 Build without EMU_FF_SCAN_CHECKSUM_EN: checksum=0 throughout all of the above scenarios.

Source files
------------

// File: rtl/emu_ff_scan_pkg.sv
// Shared definitions for the emulator flip-flop scan controller.
// Holds the controller state encoding and the default scan beat width.
package emu_ff_scan_pkg;

  localparam int DEFAULT_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DUMP    = 2'd1,
    RESTORE = 2'd2,
    FIN     = 2'd3
  } state_t;

endpackage

// File: rtl/emu_ff_scan_ctrl.sv
// Emulator flip-flop scan controller.
// Dumps the FF scan chain to a beat stream (with loopback so the chain keeps
// its content) or restores it from a beat stream. The DUT is held in halt for
// the whole operation. The optional XOR checksum of the transferred beats is
// built only when EMU_FF_SCAN_CHECKSUM_EN is defined; otherwise checksum is 0.
//
// Stream handshakes: a beat moves on a clock edge where valid and ready are
// both high. On the dump side the controller drives dout_valid, on the restore
// side din_ready; in either case that beat is also exactly the cycle in which
// ff_scan is high, so the chain shifts once per stream transfer and never
// otherwise. During an abort cycle the controller drops its own valid/ready
// together with ff_scan so no stream beat is consumed without a shift.
module emu_ff_scan_ctrl
  import emu_ff_scan_pkg::*;
#(
  parameter int CHAIN_BEATS = 3,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_dump,
  input  logic                  start_restore,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  halt,
  output logic                  ff_scan,
  output logic [DATA_WIDTH-1:0] ff_sdi,
  input  logic [DATA_WIDTH-1:0] ff_sdo,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_data,
  output logic [DATA_WIDTH-1:0] checksum,
  output state_t                dbg_state
);

  localparam int                CNT_W     = $clog2(CHAIN_BEATS + 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(CHAIN_BEATS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_xfer;
  logic             w_last;
  logic             w_start;

  assign w_last    = (r_cnt == LAST_BEAT);
  assign w_xfer    = ff_scan;
  assign w_start   = (r_state == IDLE) && (start_dump || start_restore);
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state: dump wins over restore, abort only matters while shifting.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_dump)         w_next = DUMP;
        else if (start_restore) w_next = RESTORE;
      end
      DUMP, RESTORE: begin
        if (abort)                 w_next = IDLE;
        else if (w_xfer && w_last) w_next = FIN;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs: stream and chain controls decoded from state and handshakes.
  always_comb begin
    halt       = (r_state != IDLE);
    busy       = (r_state != IDLE);
    done       = (r_state == FIN);
    ff_scan    = 1'b0;
    ff_sdi     = '0;
    dout_valid = 1'b0;
    dout_data  = '0;
    din_ready  = 1'b0;
    case (r_state)
      DUMP: begin
        dout_valid = !abort;
        dout_data  = ff_sdo;
        ff_sdi     = ff_sdo;
        ff_scan    = dout_ready && !abort;
      end
      RESTORE: begin
        din_ready = !abort;
        ff_sdi    = din_data;
        ff_scan   = din_valid && !abort;
      end
      default: ;
    endcase
  end

  // Beat counter: one step per transfer, cleared on the last beat or on leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end else if (w_next == IDLE) begin
      r_cnt <= '0;
    end
  end

`ifdef EMU_FF_SCAN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Checksum: restart on an accepted start, fold in every transferred beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum ^ ff_sdi;
    end
  end

  assign checksum = r_checksum;
`else
  logic w_unused_start;
  assign w_unused_start = w_start;
  assign checksum       = '0;
`endif

endmodule

// File: tb/tb_emu_ff_scan_ctrl.sv
// Bench for emu_ff_scan_ctrl (CHAIN_BEATS=3, DATA_WIDTH=64).
// The scan chain is modelled as a queue: its head is ff_sdo, and each cycle
// with ff_scan high drops the head and appends ff_sdi. The reference keeps the
// abstract chain content (mem) and derives expected stream beats, checksums
// and done timing from it.
`timescale 1ns/1ps
module tb_emu_ff_scan_ctrl;
  import emu_ff_scan_pkg::*;

  localparam int CB = 3;
  localparam int DW = 64;
`ifdef EMU_FF_SCAN_CHECKSUM_EN
  localparam bit CKS_ON = 1'b1;
`else
  localparam bit CKS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_dump, start_restore, abort;
  logic          busy, done, halt, ff_scan;
  logic [DW-1:0] ff_sdi, ff_sdo;
  logic          dout_valid, dout_ready;
  logic [DW-1:0] dout_data;
  logic          din_valid, din_ready;
  logic [DW-1:0] din_data;
  logic [DW-1:0] checksum;
  state_t        dbg_state;

  // Clock.
  always #5 clk = ~clk;

  emu_ff_scan_ctrl #(.CHAIN_BEATS(CB), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_dump(start_dump), .start_restore(start_restore), .abort(abort),
    .busy(busy), .done(done), .halt(halt),
    .ff_scan(ff_scan), .ff_sdi(ff_sdi), .ff_sdo(ff_sdo),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .checksum(checksum), .dbg_state(dbg_state)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] chain_q[$];
  logic [DW-1:0] mem[CB];
  logic [DW-1:0] last_cks;
  bit            pend = 1'b0;
  logic [DW-1:0] pend_d;

  logic          s_busy, s_done, s_halt, s_scan, s_dv, s_dr;
  logic [DW-1:0] s_sdi, s_ddata, s_cks;
  state_t        s_st;

  typedef struct {
    logic [4:0] in;   // {start_dump, start_restore, abort, dout_ready, din_valid}
    logic [4:0] ex;   // {busy, done, ff_scan, dout_valid, din_ready}
    state_t     st;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [DW-1:0] cks_exp(input logic [DW-1:0] x);
    return x & {DW{CKS_ON}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: apply the chain shift from the previous edge, drive inputs at
  // the falling edge, sample outputs 2ns later and score any dump beat.
  task automatic step(input bit sd, input bit sr, input bit ab, input bit rdy,
                      input bit vld, input logic [DW-1:0] dd);
    @(negedge clk);
    if (pend) begin
      chain_q.delete(0);
      chain_q.push_back(pend_d);
      pend = 1'b0;
    end
    ff_sdo        = chain_q[0];
    start_dump    = sd;
    start_restore = sr;
    abort         = ab;
    dout_ready    = rdy;
    din_valid     = vld;
    din_data      = dd;
    #2;
    s_busy = busy;  s_done = done; s_halt = halt; s_scan = ff_scan;
    s_dv = dout_valid; s_dr = din_ready; s_sdi = ff_sdi; s_ddata = dout_data;
    s_cks = checksum; s_st = dbg_state;
    pend   = s_scan;
    pend_d = s_sdi;
    if (s_dv && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra_beat: got %h expected no beat", s_ddata);
      end else begin
        check("sb_dout", s_ddata, exp_q.pop_front());
      end
    end
  endtask

  task automatic check_chain(input string name);
    check({name, "_len"}, chain_q.size(), CB);
    for (int i = 0; i < CB; i++) check(name, chain_q[i], mem[i]);
  endtask

  // One complete operation with random handshake gaps (pct = chance per cycle
  // that the stream side is ready/valid). Ends on the done cycle.
  task automatic run_op(input bit is_dump, input int pct, input bit use_fixed,
                        input logic [DW-1:0] fixed[CB]);
    logic [DW-1:0] beats[CB];
    logic [DW-1:0] x;
    logic [DW-1:0] dd;
    int            k;
    int            cyc;
    bit            r;
    x = '0;
    for (int i = 0; i < CB; i++) begin
      if (is_dump)        beats[i] = mem[i];
      else if (use_fixed) beats[i] = fixed[i];
      else                beats[i] = {$urandom, $urandom};
      x ^= beats[i];
      if (is_dump) exp_q.push_back(beats[i]);
    end
    step(is_dump, !is_dump, 1'b0, 1'b0, 1'b0, '0);
    check("op_start_idle", s_busy, 1'b0);
    check("op_cks_hold", s_cks, last_cks);
    k   = 0;
    cyc = 0;
    while (k < CB && cyc < 200) begin
      r  = ($urandom_range(99) < pct);
      dd = r ? beats[k] : {$urandom, $urandom};
      step(1'b0, 1'b0, 1'b0, is_dump ? r : 1'b0, is_dump ? 1'b0 : r, dd);
      cyc++;
      check("op_busy", s_busy, 1'b1);
      check("op_halt", s_halt, 1'b1);
      check("op_done_early", s_done, 1'b0);
      check("op_scan", s_scan, r);
      check("op_dv", s_dv, is_dump);
      check("op_dr", s_dr, !is_dump);
      check("op_state", s_st, is_dump ? DUMP : RESTORE);
      check("op_sdi", s_sdi, is_dump ? ff_sdo : dd);
      if (r) k++;
    end
    if (k < CB) begin
      n_tests++;
      n_fail++;
      $display("FAIL op_timeout: got %0d beats expected %0d", k, CB);
    end
    step(1'b0, 1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), {$urandom, $urandom});
    check("fin_done", s_done, 1'b1);
    check("fin_busy", s_busy, 1'b1);
    check("fin_scan", s_scan, 1'b0);
    check("fin_dv", s_dv, 1'b0);
    check("fin_dr", s_dr, 1'b0);
    check("fin_sdi", s_sdi, '0);
    check("fin_state", s_st, FIN);
    check("fin_cks", s_cks, cks_exp(x));
    check("sb_empty", exp_q.size(), 0);
    if (pct == 100) check("op_latency", cyc + 1, CB + 1);
    if (!is_dump) for (int i = 0; i < CB; i++) mem[i] = beats[i];
    check_chain("op_chain");
    last_cks = cks_exp(x);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] fixed[CB];
    logic [DW-1:0] n0;
    vec_t          v;

    start_dump = 0; start_restore = 0; abort = 0;
    dout_ready = 0; din_valid = 0; din_data = '0;
    mem[0] = 64'hAAAA_0001_0000_000A;
    mem[1] = 64'hBBBB_0002_0000_000B;
    mem[2] = 64'hCCCC_0003_0000_000C;
    for (int i = 0; i < CB; i++) chain_q.push_back(mem[i]);
    ff_sdo = chain_q[0];
    fixed[0] = {16{4'h1}};
    fixed[1] = {16{4'h2}};
    fixed[2] = {16{4'h3}};

    // Reset state.
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_halt", halt, 1'b0);
    check("rst_scan", ff_scan, 1'b0);
    check("rst_dv", dout_valid, 1'b0);
    check("rst_dr", din_ready, 1'b0);
    check("rst_cks", checksum, '0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: both starts (dump wins), ready toggling 1,0,0,1,1,
    // starts ignored while busy, abort ignored in FIN and IDLE.
    tbl[0] = '{5'b00000, 5'b00000, IDLE};
    tbl[1] = '{5'b11011, 5'b00000, IDLE};
    tbl[2] = '{5'b00011, 5'b10110, DUMP};
    tbl[3] = '{5'b01000, 5'b10010, DUMP};
    tbl[4] = '{5'b10000, 5'b10010, DUMP};
    tbl[5] = '{5'b00010, 5'b10110, DUMP};
    tbl[6] = '{5'b00010, 5'b10110, DUMP};
    tbl[7] = '{5'b00111, 5'b11000, FIN};
    tbl[8] = '{5'b00100, 5'b00000, IDLE};
    for (int i = 0; i < CB; i++) exp_q.push_back(mem[i]);
    for (int i = 0; i < 9; i++) begin
      v = tbl[i];
      step(v.in[4], v.in[3], v.in[2], v.in[1], v.in[0], {$urandom, $urandom});
      check("tbl_busy", s_busy, v.ex[4]);
      check("tbl_halt", s_halt, v.ex[4]);
      check("tbl_done", s_done, v.ex[3]);
      check("tbl_scan", s_scan, v.ex[2]);
      check("tbl_dv", s_dv, v.ex[1]);
      check("tbl_dr", s_dr, v.ex[0]);
      check("tbl_state", s_st, v.st);
      check("tbl_sdi", s_sdi, (v.st == DUMP) ? ff_sdo : '0);
      if (i >= 7) check("tbl_cks", s_cks, cks_exp(mem[0] ^ mem[1] ^ mem[2]));
    end
    check("tbl_sb_empty", exp_q.size(), 0);
    check_chain("tbl_chain");
    last_cks = cks_exp(mem[0] ^ mem[1] ^ mem[2]);

    // Unstalled dump (latency), restore of fixed values with gaps, dump back.
    run_op(1'b1, 100, 1'b0, fixed);
    run_op(1'b0, 50, 1'b1, fixed);
    run_op(1'b1, 100, 1'b0, fixed);

    // Abort a restore after one beat.
    n0 = {$urandom, $urandom};
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n0);
    check("ab_first_scan", s_scan, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {$urandom, $urandom});
    check("ab_scan", s_scan, 1'b0);
    check("ab_done", s_done, 1'b0);
    check("ab_busy", s_busy, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("ab_after_halt", s_halt, 1'b0);
    check("ab_after_done", s_done, 1'b0);
    check("ab_after_state", s_st, IDLE);
    for (int i = 0; i < CB - 1; i++) mem[i] = mem[i + 1];
    mem[CB-1] = n0;
    check_chain("ab_chain");
    last_cks = cks_exp(n0);
    run_op(1'b1, 100, 1'b0, fixed);

    // Reset in the middle of a restore.
    n0 = {$urandom, $urandom};
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {$urandom, $urandom});
    check("mr_pre_dr", s_dr, 1'b1);
    pend  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 1'b0);
    check("mr_halt", halt, 1'b0);
    check("mr_done", done, 1'b0);
    check("mr_scan", ff_scan, 1'b0);
    check("mr_dv", dout_valid, 1'b0);
    check("mr_dr", din_ready, 1'b0);
    check("mr_cks", checksum, '0);
    check("mr_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    check("mr_hold_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < CB - 1; i++) mem[i] = mem[i + 1];
    mem[CB-1] = n0;
    last_cks = '0;
    run_op(1'b1, 100, 1'b0, fixed);

    // Random operations, back to back.
    for (int n = 0; n < 24; n++) begin
      run_op(1'($urandom_range(1)), $urandom_range(100, 30), 1'b0, fixed);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
